imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_word_pack.sv | 60 ++++++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM state set and the word/address geometry.
package imem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, memory write port and status bundle of the loader.
// The loader is the slave; the stream source and memory side are the master.
interface imem_loader_if #(
    parameter int unsigned Width = 32
);
    import imem_loader_pkg::*;

    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [Width-1:0]  wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_rst_n;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata, busy, done, err, cpu_rst_n
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata, busy, done, err, cpu_rst_n
    );

endinterface

// File: rtl/imem_word_pack.sv
// Packs accepted bytes big-endian into words and emits a registered
// one-cycle word_valid_o on the cycle after each word's last byte.
module imem_word_pack
    import imem_loader_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic [7:0]       byte_i,
    output logic             full_o,
    output logic             word_valid_o,
    output logic [Width-1:0] word_o
);
    logic [Width-1:0] sr_q, sr_d, word_q, word_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [Width-1:0] shifted;

    assign shifted = {sr_q[Width-9:0], byte_i};
    assign full_o  = accept_i && (cnt_q == 2'(WORD_BYTES - 1));

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept_i) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 2'd1;
            if (full_o) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory and releases the processor reset only after a good load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 256
) (
    input logic          clk,
    input logic          rst_n,
    imem_loader_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, wcnt_q, wcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              ready, busy, done, err, cpu_rst_n;
    logic              go, accept, word_full, last_word, word_valid;
    logic [Width-1:0]  word;

    assign go        = bus.start && (state_q inside {StIdle, StDone, StErr});
    assign accept    = bus.byte_valid && ready;
    assign last_word = word_full && ((wcnt_q + (ADDR_W + 1)'(1)) == len_q);

    imem_word_pack #(
        .Width (Width)
    ) u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (go),
        .accept_i     (accept && (state_q == StData)),
        .byte_i       (bus.byte_in),
        .full_o       (word_full),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            wcnt_q  <= '0;
            csum_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            waddr_q <= waddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: if (bus.start) state_d = StLen;
            StLen:                 if (accept) state_d = StData;
            StData:                if (last_word) state_d = StCsum;
            StCsum: begin
                if (accept) state_d = (bus.byte_in == csum_q) ? StDone : StErr;
            end
            default:               state_d = StIdle;
        endcase
    end

    // A zero length byte encodes a full memory of Depth words.
    always_comb begin
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        csum_d  = csum_q;
        waddr_d = waddr_q;
        if (go) begin
            len_d   = '0;
            wcnt_d  = '0;
            csum_d  = '0;
            waddr_d = '0;
        end else begin
            if (accept && state_q == StLen) begin
                len_d = (bus.byte_in == 8'd0) ? (ADDR_W + 1)'(Depth) : {1'b0, bus.byte_in};
            end
            if (accept && state_q == StData) csum_d = csum_q ^ bus.byte_in;
            if (word_full) wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
            if (word_valid) waddr_d = waddr_q + 1'b1;
        end
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_rst_n = 1'b0;
        unique case (state_q)
            StLen, StData, StCsum: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            StDone: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            StErr:   err = 1'b1;
            default: ;
        endcase
    end

    assign bus.byte_ready = ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.cpu_rst_n  = cpu_rst_n;
    assign bus.we         = word_valid;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a
// stream-level model of expected writes and final status.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [39:0] wq[$];

    imem_loader_if #(.Width(32)) bus ();

    imem_loader #(
        .Width (32),
        .Depth (256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we === 1'b1) wq.push_back({bus.waddr, bus.wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected test end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'(exp_done));
        check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        check({tag, "_cpu_rst_n"}, 64'(bus.cpu_rst_n), 64'(exp_done));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered and left at a negedge; byte_in carries junk whenever valid is low.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g = gaps ? int'($urandom_range(0, 3)) : 0;
        int k = 0;
        repeat (g) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
    endtask

    task automatic run_load(input logic [31:0] words[$], input logic [7:0] n_code,
                            input bit bad_csum, input bit gaps, input bit mid_start,
                            input string tag);
        logic [7:0] bytes[$];
        logic [7:0] csum = 8'h00;
        int exp_n = (n_code == 8'd0) ? 256 : int'(n_code);
        logic [39:0] obs;
        foreach (words[w]) begin
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(words[w][31-8*k -: 8]);
                csum ^= words[w][31-8*k -: 8];
            end
        end
        wq.delete();
        pulse_start();
        check({tag, "_busy_at_len"}, 64'(bus.busy), 64'd1);
        check({tag, "_hold_at_len"}, 64'(bus.cpu_rst_n), 64'd0);
        send_byte(n_code, gaps);
        foreach (bytes[i]) begin
            if (mid_start && i == 10) pulse_start();
            send_byte(bytes[i], gaps);
        end
        send_byte(bad_csum ? ~csum : csum, gaps);
        repeat (2) @(negedge clk);
        check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            obs = (i < wq.size()) ? wq[i] : 40'hx;
            check($sformatf("%s_waddr%0d", tag, i), 64'(obs[39:32]), 64'(i[7:0]));
            check($sformatf("%s_wdata%0d", tag, i), 64'(obs[31:0]), 64'(words[i]));
        end
        check_status(tag, !bad_csum, bad_csum);
    endtask

    initial begin
        logic [31:0] fact[$];
        logic [31:0] rnd[$];
        logic [31:0] one[$];
        fact = '{32'h00500513, 32'h00100593, 32'h00050863, 32'h02a585b3, 32'hfff50513,
                 32'hff5ff06f, 32'h00b02023, 32'h0000006f, 32'h00000013};
        for (int i = 0; i < 256; i++) rnd.push_back($urandom);
        one = '{32'h00008020};
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_waddr", 64'(bus.waddr), 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        check_status("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_status("idle", 1'b0, 1'b0);

        run_load(fact, 8'd9, 1'b0, 1'b0, 1'b0, "fact");
        repeat (5) @(negedge clk);
        check_status("fact_hold", 1'b1, 1'b0);

        run_load(fact, 8'd9, 1'b1, 1'b0, 1'b0, "badcs");
        run_load(rnd, 8'd0, 1'b0, 1'b0, 1'b0, "full");
        run_load(fact, 8'd9, 1'b0, 1'b1, 1'b1, "gaps");

        // Abort after the second byte of word 3, then reload one word.
        pulse_start();
        send_byte(8'd9, 1'b0);
        for (int i = 0; i < 14; i++) send_byte(fact[i/4][31-8*(i%4) -: 8], 1'b0);
        #2 rst_n = 1'b0;
        wq.delete();
        #1;
        check("abort_we", 64'(bus.we), 64'd0);
        check("abort_waddr", 64'(bus.waddr), 64'd0);
        check("abort_wdata", 64'(bus.wdata), 64'd0);
        check_status("abort", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_stray_we", 64'(wq.size()), 64'd0);
        run_load(one, 8'd1, 1'b0, 1'b0, 1'b0, "fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
